// File: rtl/tokenflow_sync_source.sv
// -----------------------------------------------------------------------------
// tokenflow_sync_source
//
// Purpose:
//   Clocked token producer. A forward-difference generator produces the
//   quadratic sequence y(n) = A*n^2 + B*n (mod 2^W), buffers it in a
//   DEPTH-entry FIFO and emits each value on a bundled-data req/ack channel
//   running either 4-phase (return-to-zero) or 2-phase (transition) signalling.
//
// Optional feature macro:
//   TOKENFLOW_ACK_SYNC_EN -- when defined, out_ack is passed through a
//   two-flop synchroniser before the channel FSM sees it (needed for pad or
//   otherwise asynchronous acks; adds 2 cycles of ack latency). When
//   undefined, the FSM uses out_ack directly and the environment must drive
//   out_ack from clk.
//
// Parameters:
//   W          data width, all arithmetic mod 2^W
//   DEPTH      FIFO entries, power of two, >= 2
//   FOUR_PHASE 1 = 4-phase return-to-zero, 0 = 2-phase transition signalling
//   A, B       quadratic and linear coefficients
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   synchronous, active-high
//   en        in   generator enable (0 = no new tokens produced)
//   out_ack   in   channel acknowledge from the environment
//   out_req   out  channel request (registered)
//   out_data  out  channel data, bundled with out_req (registered)
//   level     out  FIFO occupancy, 0..DEPTH (registered)
// -----------------------------------------------------------------------------
module tokenflow_sync_source #(
   parameter int unsigned W          = 16,
   parameter int unsigned DEPTH      = 4,
   parameter bit          FOUR_PHASE = 1'b1,
   parameter int unsigned A          = 1,
   parameter int unsigned B          = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   out_ack,
   output logic                   out_req,
   output logic [W-1:0]           out_data,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned PW       = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   LVL_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   LVL_FULL = (PW+1)'(DEPTH);
   // Forward differences: first step is y(1)-y(0) = A+B, second difference is 2A.
   localparam logic [W-1:0]  DIFF_RST  = W'(A + B);
   localparam logic [W-1:0]  DIFF_STEP = W'(2 * A);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_WAIT_HI,
      ST_WAIT_LO
   } state_e;

   // Channel state and registered outputs
   state_e         state_q, state_d;
   logic           req_q, req_d;
   logic [W-1:0]   data_q, data_d;

   // Generator
   logic [W-1:0]   y_q, y_d;
   logic [W-1:0]   diff_q, diff_d;

   // FIFO
   logic [W-1:0]   mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PW:0]    level_q, level_d;

   logic           ack_s;
   logic           push;
   logic           pop;

   // ---------------------------------------------------------------------------
   // Ack path
   // ---------------------------------------------------------------------------
`ifdef TOKENFLOW_ACK_SYNC_EN
   logic ack_meta_q;
   logic ack_sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ack_meta_q <= 1'b0;
         ack_sync_q <= 1'b0;
      end else begin
         ack_meta_q <= out_ack;
         ack_sync_q <= ack_meta_q;
      end
   end

   assign ack_s = ack_sync_q;
`else
   assign ack_s = out_ack;
`endif

   // ---------------------------------------------------------------------------
   // Channel FSM next-state / output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      pop     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // In 4-phase mode the previous handshake must have fully returned to zero.
            if ((level_q != '0) && (!FOUR_PHASE || !ack_s)) begin
               state_d = ST_SETUP;
               data_d  = mem_q[rd_ptr_q];
            end
         end
         ST_SETUP: begin
            // Data was launched last edge, so it is stable for a full cycle before req moves.
            state_d = ST_WAIT_HI;
            req_d   = FOUR_PHASE ? 1'b1 : ~req_q;
         end
         ST_WAIT_HI: begin
            if (FOUR_PHASE) begin
               if (ack_s) begin
                  pop     = 1'b1;
                  req_d   = 1'b0;
                  state_d = ST_WAIT_LO;
               end
            end else if (ack_s == req_q) begin
               pop     = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_LO: begin
            if (!ack_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Generator and FIFO bookkeeping
   // ---------------------------------------------------------------------------
   always_comb begin
      // Full is judged on the current level: a pop this cycle does not open a slot.
      push     = en && (level_q != LVL_FULL);
      y_d      = y_q;
      diff_d   = diff_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;

      if (push) begin
         y_d      = y_q + diff_q;
         diff_d   = diff_q + DIFF_STEP;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      if (push && !pop) begin
         level_d = level_q + LVL_ONE;
      end else if (pop && !push) begin
         level_d = level_q - LVL_ONE;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         req_q    <= 1'b0;
         data_q   <= '0;
         y_q      <= '0;
         diff_q   <= DIFF_RST;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         data_q   <= data_d;
         y_q      <= y_d;
         diff_q   <= diff_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // NOTE: FIFO storage is deliberately not reset; the pointers and level are,
   // so stale entries are never read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= y_q;
      end
   end

   assign out_req  = req_q;
   assign out_data = data_q;
   assign level    = level_q;

endmodule

// File: tb/tb_tokenflow_sync_source.sv
// -----------------------------------------------------------------------------
// tb_tokenflow_sync_source
//
// Two instances: dut4 (W=16, 4-phase) and dut2 (W=8, 2-phase), each with a
// clocked environment that either forces out_ack or echoes out_req after a
// fixed number of clk edges. A monitor logs every token at its req edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tokenflow_sync_source;

   localparam int W4 = 16;
   localparam int W2 = 8;

`ifdef TOKENFLOW_ACK_SYNC_EN
   localparam int SYNC_LAT = 2;
   localparam int ENV_DLY4 = 0;   // ack tied straight to req
`else
   localparam int SYNC_LAT = 0;
   localparam int ENV_DLY4 = 1;   // ack is a clocked copy of req
`endif
   localparam int ENV_DLY2 = 3;
   // 4-phase: SETUP 1 + WAIT_HI (1+D+S) + WAIT_LO (1+D+S) + IDLE 1
   localparam int PERIOD4  = 4 + 2 * (ENV_DLY4 + SYNC_LAT);
   // 2-phase: SETUP 1 + WAIT_HI (1+D+S) + IDLE 1
   localparam int PERIOD2  = 3 + ENV_DLY2 + SYNC_LAT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst4, en4, ack4, req4;
   logic [W4-1:0]   data4;
   logic [2:0]      level4;
   logic            rst2, en2, ack2, req2;
   logic [W2-1:0]   data2;
   logic [2:0]      level2;

   tokenflow_sync_source #(.W(W4), .DEPTH(4), .FOUR_PHASE(1'b1), .A(1), .B(1)) dut4 (
      .clk(clk), .reset(rst4), .en(en4), .out_ack(ack4),
      .out_req(req4), .out_data(data4), .level(level4)
   );

   tokenflow_sync_source #(.W(W2), .DEPTH(4), .FOUR_PHASE(1'b0), .A(1), .B(1)) dut2 (
      .clk(clk), .reset(rst2), .en(en2), .out_ack(ack2),
      .out_req(req2), .out_data(data2), .level(level2)
   );

   // ---------------- environment: forced ack or delayed echo of req ----------
   logic       ack_loop4 = 1'b0, ack_force4 = 1'b0;
   logic       ack_loop2 = 1'b0, ack_force2 = 1'b0;
   logic [3:0] hist4, hist2;
   logic [4:0] tap4, tap2;

   always @(posedge clk) begin
      if (rst4) hist4 <= '0; else hist4 <= {hist4[2:0], req4};
      if (rst2) hist2 <= '0; else hist2 <= {hist2[2:0], req2};
   end
   assign tap4 = {hist4, req4};
   assign tap2 = {hist2, req2};
   assign ack4 = ack_loop4 ? tap4[ENV_DLY4] : ack_force4;
   assign ack2 = ack_loop2 ? tap2[ENV_DLY2] : ack_force2;

   // ---------------- cycle counter and token monitors -------------------------
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [W4-1:0] tok4 [$];
   int            tcyc4 [$];
   logic [W2-1:0] tok2 [$];
   int            tcyc2 [$];
   logic          treq2 [$];
   logic          prev4 = 1'b0, prev2 = 1'b0;

   always @(negedge clk) begin
      if (rst4) begin
         prev4 <= 1'b0;
      end else begin
         if (req4 && !prev4) begin
            tok4.push_back(data4);
            tcyc4.push_back(cyc);
         end
         prev4 <= req4;
      end
      if (rst2) begin
         prev2 <= 1'b0;
      end else begin
         if (req2 !== prev2) begin
            tok2.push_back(data2);
            tcyc2.push_back(cyc);
            treq2.push_back(req2);
         end
         prev2 <= req2;
      end
   end

   // ---------------- checking helpers -----------------------------------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: y(n) = n^2 + n, mod 2^w
   function automatic logic [63:0] model(input int n, input int w);
      longint v;
      v = longint'(n) * longint'(n) + longint'(n);
      return 64'(v) & ((64'd1 << w) - 64'd1);
   endfunction

   function automatic logic [63:0] tok4_at(input int i);
      if (i < tok4.size()) return 64'(tok4[i]);
      return 'x;
   endfunction

   function automatic logic [63:0] tok2_at(input int i);
      if (i < tok2.size()) return 64'(tok2[i]);
      return 'x;
   endfunction

   function automatic longint cyc4_at(input int i);
      if (i < tcyc4.size()) return longint'(tcyc4[i]);
      return -1000;
   endfunction

   function automatic longint cyc2_at(input int i);
      if (i < tcyc2.size()) return longint'(tcyc2[i]);
      return -1000;
   endfunction

   // Hold reset for two edges, clear logs, release on a falling edge.
   // base = counter value just before edge 0.
   task automatic reset4(output int base);
      @(negedge clk); rst4 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tok4.delete(); tcyc4.delete();
      @(negedge clk); rst4 = 1'b0;
      base = cyc;
   endtask

   task automatic reset2(output int base);
      @(negedge clk); rst2 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tok2.delete(); tcyc2.delete(); treq2.delete();
      @(negedge clk); rst2 = 1'b0;
      base = cyc;
   endtask

   task automatic wait4(input int n, input int budget);
      int k;
      k = 0;
      while (tok4.size() < n && k < budget) begin @(posedge clk); k++; end
      #1;
      check("tok4_count", 64'(tok4.size() >= n), 64'd1);
   endtask

   task automatic wait2(input int n, input int budget);
      int k;
      k = 0;
      while (tok2.size() < n && k < budget) begin @(posedge clk); k++; end
      #1;
      check("tok2_count", 64'(tok2.size() >= n), 64'd1);
   endtask

   // ---------------- vector table record --------------------------------------
   typedef struct {
      logic          rst;
      logic          en;
      logic          req;
      logic [W4-1:0] data;
      logic [2:0]    lvl;
   } vec_t;

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t vt [12];
      int   base;
      int   n;
      int   k;
      int   sz;

      rst4 = 1'b1; en4 = 1'b0;
      rst2 = 1'b1; en2 = 1'b0;

      // dut4, ack held low: reset, startup latency, level saturation at DEPTH.
      vt[0]  = '{1'b1, 1'b0, 1'b0, 16'd0, 3'd0};
      vt[1]  = '{1'b1, 1'b1, 1'b0, 16'd0, 3'd0};  // reset wins over en
      vt[2]  = '{1'b0, 1'b1, 1'b0, 16'd0, 3'd1};  // edge 0: y0 pushed
      vt[3]  = '{1'b0, 1'b1, 1'b0, 16'd0, 3'd2};  // edge 1: SETUP, data=y0
      vt[4]  = '{1'b0, 1'b1, 1'b1, 16'd0, 3'd3};  // edge 2: req rises
      vt[5]  = '{1'b0, 1'b1, 1'b1, 16'd0, 3'd4};  // full
      vt[6]  = '{1'b0, 1'b1, 1'b1, 16'd0, 3'd4};  // full, no push
      vt[7]  = '{1'b0, 1'b0, 1'b1, 16'd0, 3'd4};
      vt[8]  = '{1'b1, 1'b1, 1'b0, 16'd0, 3'd0};  // reset mid-handshake
      vt[9]  = '{1'b0, 1'b0, 1'b0, 16'd0, 3'd0};  // en low: nothing pushed
      vt[10] = '{1'b0, 1'b1, 1'b0, 16'd0, 3'd1};
      vt[11] = '{1'b0, 1'b1, 1'b0, 16'd0, 3'd2};

      repeat (2) @(posedge clk);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         rst4 = vt[i].rst;
         en4  = vt[i].en;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_req", i),   64'(req4),   64'(vt[i].req));
         check($sformatf("vec%0d_data", i),  64'(data4),  64'(vt[i].data));
         check($sformatf("vec%0d_level", i), 64'(level4), 64'(vt[i].lvl));
      end

      // ---- Saturation with ack held low, ack latency, then resume -----------
      ack_loop4 = 1'b0; ack_force4 = 1'b0; en4 = 1'b1;
      reset4(base);
      repeat (10) @(posedge clk);
      #1;
      check("sat_level", 64'(level4), 64'd4);
      check("sat_req", 64'(req4), 64'd1);
      check("sat_first_token", tok4_at(0), 64'd0);
      repeat (5) @(posedge clk);
      #1;
      check("sat_level_hold", 64'(level4), 64'd4);
      check("sat_token_count", 64'(tok4.size()), 64'd1);

      @(negedge clk);
      en4 = 1'b0;
      ack_force4 = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (level4 == 3'd4 && n < 10);
      check("ack_to_pop_edges", 64'(n), 64'(1 + SYNC_LAT));
      check("pop_level", 64'(level4), 64'd3);
      check("pop_req_low", 64'(req4), 64'd0);

      @(negedge clk);
      ack_loop4 = 1'b1;
      en4 = 1'b1;
      wait4(8, 300);
      for (int i = 0; i < 8; i++)
         check($sformatf("resume_tok%0d", i), tok4_at(i), model(i, W4));
      for (int i = 1; i < 7; i++)
         check($sformatf("resume_gap%0d", i), 64'(cyc4_at(i + 1) - cyc4_at(i)), 64'(PERIOD4));

      // ---- Startup with loopback: first req after edge 2, steady period ----
      reset4(base);
      wait4(6, 200);
      check("start_first_rise", 64'(cyc4_at(0)), 64'(base + 3));
      for (int i = 0; i < 6; i++)
         check($sformatf("start_tok%0d", i), tok4_at(i), model(i, W4));
      for (int i = 0; i < 5; i++)
         check($sformatf("start_gap%0d", i), 64'(cyc4_at(i + 1) - cyc4_at(i)), 64'(PERIOD4));

      // ---- Reset while req is high -----------------------------------------
      k = 0;
      @(negedge clk);
      while (req4 !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      check("midreset_req_seen", 64'(req4), 64'd1);
      rst4 = 1'b1;
      @(posedge clk);
      #1;
      check("midreset_req", 64'(req4), 64'd0);
      check("midreset_level", 64'(level4), 64'd0);
      check("midreset_data", 64'(data4), 64'd0);
      tok4.delete(); tcyc4.delete();
      @(negedge clk);
      rst4 = 1'b0;
      base = cyc;
      wait4(3, 100);
      check("midreset_tok0", tok4_at(0), 64'd0);
      check("midreset_tok1", tok4_at(1), 64'd2);
      check("midreset_tok2", tok4_at(2), 64'd6);
      check("midreset_first_rise", 64'(cyc4_at(0)), 64'(base + 3));

      // ---- 2-phase, W=8, ack echoes req after 3 edges: wrap + toggling -----
      ack_loop2 = 1'b1; en2 = 1'b1;
      reset2(base);
      wait2(20, 600);
      check("p2_first_toggle", 64'(cyc2_at(0)), 64'(base + 3));
      for (int i = 0; i < 20; i++)
         check($sformatf("p2_tok%0d", i), tok2_at(i), model(i, W2));
      check("p2_wrap_tok15", tok2_at(15), 64'd240);
      check("p2_wrap_tok16", tok2_at(16), 64'd16);
      for (int i = 0; i < 6; i++) begin
         // One transition per token: req level alternates 1,0,1,0,...
         check($sformatf("p2_req_phase%0d", i),
               (i < treq2.size()) ? 64'(treq2[i]) : 'x, 64'((i % 2) == 0));
         check($sformatf("p2_gap%0d", i), 64'(cyc2_at(i + 1) - cyc2_at(i)), 64'(PERIOD2));
      end

      // ---- en low: FIFO drains, level reaches 0, no more tokens ------------
      @(negedge clk);
      en2 = 1'b0;
      k = 0;
      while (level2 != 3'd0 && k < 200) begin @(posedge clk); #1; k++; end
      check("drain_level", 64'(level2), 64'd0);
      repeat (3 * PERIOD2) @(posedge clk);
      #1;
      sz = tok2.size();
      repeat (20) @(posedge clk);
      #1;
      check("drain_no_more_tokens", 64'(tok2.size()), 64'(sz));
      for (int i = 20; i < sz; i++)
         check($sformatf("drain_tok%0d", i), tok2_at(i), model(i, W2));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
